div64x32_iter: RTL and testbench

Iterative restoring divider: divides a 64-bit dividend by a 32-bit divisor and returns a 32-bit quotient and a 32-bit remainder, one quotient bit per clock. It is the inverse of the 32x32 iterative multiplier: a 64-bit product and one of its factors go in, and the other factor comes back. It uses the same start/busy handshake as the multiplier, so the same controller can sequence both. A start/busy FSM and a shift/subtract datapath fit in one module.

---
 rtl/div64x32_iter.sv | 105 ++++++++++
 tb/tb_div64x32_iter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div64x32_iter.sv
// Iterative restoring divider: 64-bit dividend / 32-bit divisor, one quotient bit per clock.
// Shares the start/busy handshake of the 32x32 iterative multiplier.
module div64x32_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CALC  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] rem_q;     // partial remainder, always < divisor once in CALC
  logic [31:0] dlo;       // low dividend bits shifting out, quotient bits shifting in
  logic [31:0] dvs;
  logic [4:0]  cnt;

  logic [32:0] trial;
  logic [31:0] diff;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] dlo_next;

  // One restoring step. The true difference is below the divisor whenever it is
  // kept, so a 32-bit subtract is exact even though the trial value is 33 bits.
  always_comb begin
    trial    = {rem_q, dlo[31]};
    diff     = trial[31:0] - dvs;
    q_bit    = (trial >= {1'b0, dvs});
    rem_next = q_bit ? diff : trial[31:0];
    dlo_next = {dlo[30:0], q_bit};
  end

  assign busy = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rem_q       <= '0;
      dlo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dlo   <= dividend[31:0];
            rem_q <= dividend[63:32];
            dvs   <= divisor;
            cnt   <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (dvs == '0) begin
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            quotient    <= '1;
            remainder   <= '0;
            state       <= IDLE;
          end else if (rem_q >= dvs) begin
            // Quotient would not fit in 32 bits.
            overflow    <= 1'b1;
            div_by_zero <= 1'b0;
            quotient    <= '1;
            remainder   <= '0;
            state       <= IDLE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_next;
          dlo   <= dlo_next;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            quotient    <= dlo_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div64x32_iter.sv
// Self-checking bench for div64x32_iter: directed cases, exceptions, random
// operands against a 64-bit arithmetic reference, handshake and reset scenarios.
module tb_div64x32_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int tests;
  int fails;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    logic [7:0]  cyc;
  } res_t;

  res_t last;  // expected held outputs from the most recent completion

  div64x32_iter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [63:0] dd, input logic [31:0] dv);
    res_t m;
    logic [63:0] q64;
    m = '0;
    if (dv == 32'd0) begin
      m.q = 32'hFFFF_FFFF; m.dbz = 1'b1; m.cyc = 8'd1;
    end else if (dd[63:32] >= dv) begin
      m.q = 32'hFFFF_FFFF; m.ovf = 1'b1; m.cyc = 8'd1;
    end else begin
      q64   = dd / {32'd0, dv};
      m.q   = q64[31:0];
      m.r   = 32'(dd % {32'd0, dv});
      m.cyc = 8'd33;
    end
    return m;
  endfunction

  // Launch one operation and observe it until busy falls (bounded).
  task automatic run_op(input logic [63:0] dd, input logic [31:0] dv, output res_t act);
    int cyc;
    @(negedge clk);
    dividend = dd; divisor = dv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
    end
    act = '{q: quotient, r: remainder, dbz: div_by_zero, ovf: overflow, cyc: 8'(cyc)};
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    tests++;
    if ({busy, quotient, remainder, div_by_zero, overflow} !== 67'd0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
               busy, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    last = '0;
  endtask

  task automatic test_directed;
    logic [63:0] dd [4];
    logic [31:0] dv [4];
    logic [31:0] eq [4];
    logic [31:0] er [4];
    res_t act;
    dd[0] = 64'd100;                 dv[0] = 32'd7;           eq[0] = 32'd14;          er[0] = 32'd2;
    dd[1] = 64'h0000_0001_0000_0000; dv[1] = 32'd2;           eq[1] = 32'h8000_0000;   er[1] = 32'd0;
    dd[2] = 64'hFFFF_FFFE_0000_0001; dv[2] = 32'hFFFF_FFFF;   eq[2] = 32'hFFFF_FFFF;   er[2] = 32'd0;
    dd[3] = 64'd50;                  dv[3] = 32'd3;           eq[3] = 32'd16;          er[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      run_op(dd[i], dv[i], act);
      tests++;
      if (act !== '{q: eq[i], r: er[i], dbz: 1'b0, ovf: 1'b0, cyc: 8'd33}) begin
        fails++;
        $display("FAIL directed_%0d: got q=%h r=%h dbz=%b ovf=%b busy_cycles=%0d, want q=%h r=%h flags 0 busy_cycles=33",
                 i, act.q, act.r, act.dbz, act.ovf, act.cyc, eq[i], er[i]);
      end
      last = model(dd[i], dv[i]);
    end
  endtask

  task automatic test_exceptions;
    res_t act;
    run_op(64'd123, 32'd0, act);
    tests++;
    if (act !== '{q: 32'hFFFF_FFFF, r: 32'd0, dbz: 1'b1, ovf: 1'b0, cyc: 8'd1}) begin
      fails++;
      $display("FAIL div_by_zero: got q=%h r=%h dbz=%b ovf=%b busy_cycles=%0d, want q=ffffffff r=0 dbz=1 ovf=0 busy_cycles=1",
               act.q, act.r, act.dbz, act.ovf, act.cyc);
    end
    run_op(64'h0000_0005_0000_0000, 32'd5, act);
    tests++;
    if (act !== '{q: 32'hFFFF_FFFF, r: 32'd0, dbz: 1'b0, ovf: 1'b1, cyc: 8'd1}) begin
      fails++;
      $display("FAIL overflow: got q=%h r=%h dbz=%b ovf=%b busy_cycles=%0d, want q=ffffffff r=0 dbz=0 ovf=1 busy_cycles=1",
               act.q, act.r, act.dbz, act.ovf, act.cyc);
    end
    last = model(64'h0000_0005_0000_0000, 32'd5);
  endtask

  task automatic test_random;
    logic [63:0] dd;
    logic [31:0] dv;
    logic [63:0] recon;
    res_t act, exp;
    for (int i = 0; i < 1000; i++) begin
      dv = $urandom;
      if (i % 4 == 0) dv = dv >> ($urandom % 32);
      if (dv == 32'd0) dv = 32'd1;
      dd = {$urandom % dv, $urandom};
      exp = model(dd, dv);
      run_op(dd, dv, act);
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL random_%0d: %h/%h got q=%h r=%h dbz=%b ovf=%b busy_cycles=%0d, want q=%h r=%h busy_cycles=%0d",
                 i, dd, dv, act.q, act.r, act.dbz, act.ovf, act.cyc, exp.q, exp.r, exp.cyc);
      end
      recon = {32'd0, act.q} * {32'd0, dv} + {32'd0, act.r};
      tests++;
      if (recon !== dd || act.r >= dv) begin
        fails++;
        $display("FAIL invariant_%0d: q*d+r=%h r=%h, want %h with r < %h", i, recon, act.r, dd, dv);
      end
      last = exp;
    end
  endtask

  task automatic test_ignore_start;
    res_t exp, act;
    int   cyc;
    bit   done;
    exp = model(64'd100, 32'd7);
    @(negedge clk);
    dividend = 64'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; done = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      if (busy) begin
        cyc++;
        tests++;
        if ({quotient, remainder, div_by_zero, overflow} !== {last.q, last.r, last.dbz, last.ovf}) begin
          fails++;
          $display("FAIL hold_while_busy_c%0d: got q=%h r=%h dbz=%b ovf=%b, want q=%h r=%h dbz=%b ovf=%b",
                   c, quotient, remainder, div_by_zero, overflow, last.q, last.r, last.dbz, last.ovf);
        end
        start    = (c == 5 || c == 20);
        dividend = 64'd50;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
        done  = 1'b1;
      end
    end
    act = '{q: quotient, r: remainder, dbz: div_by_zero, ovf: overflow, cyc: 8'(cyc)};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL ignore_start: got q=%h r=%h busy_cycles=%0d, want q=%h r=%h busy_cycles=33",
               act.q, act.r, act.cyc, exp.q, exp.r);
    end
    last = exp;
  endtask

  task automatic test_back_to_back;
    res_t exp, act;
    int   cyc;
    @(negedge clk);
    dividend = 64'd123; divisor = 32'd0; start = 1'b1;
    @(posedge clk);
    #1 dividend = 64'd100; divisor = 32'd7;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_check_busy: got busy=%b, want 1", busy);
    end
    @(negedge clk);
    tests++;
    if ({busy, quotient, remainder, div_by_zero, overflow} !== {1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL b2b_idle_gap: got busy=%b q=%h r=%h dbz=%b ovf=%b, want busy=0 q=ffffffff r=0 dbz=1 ovf=0",
               busy, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_reaccept: got busy=%b, want 1", busy);
    end
    cyc = busy ? 1 : 0;
    for (int i = 0; i < 200 && busy; i++) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    exp = model(64'd100, 32'd7);
    act = '{q: quotient, r: remainder, dbz: div_by_zero, ovf: overflow, cyc: 8'(cyc)};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL b2b_second_op: got q=%h r=%h dbz=%b ovf=%b busy_cycles=%0d, want q=%h r=%h busy_cycles=33",
               act.q, act.r, act.dbz, act.ovf, act.cyc, exp.q, exp.r);
    end
    last = exp;
  endtask

  task automatic test_reset_mid;
    res_t act;
    @(negedge clk);
    dividend = 64'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({busy, quotient, remainder, div_by_zero, overflow} !== 67'd0) begin
      fails++;
      $display("FAIL reset_mid_op: got busy=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
               busy, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op(64'd50, 32'd3, act);
    tests++;
    if (act !== '{q: 32'd16, r: 32'd2, dbz: 1'b0, ovf: 1'b0, cyc: 8'd33}) begin
      fails++;
      $display("FAIL after_reset_op: got q=%h r=%h busy_cycles=%0d, want q=10 r=2 busy_cycles=33",
               act.q, act.r, act.cyc);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_exceptions();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
